// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
package aes_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Per-requester operation codes.
  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  // Default number of cycles an engine is given before the job is abandoned.
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/aes_core_sched_rr_arb2.sv
// Two-input round-robin arbiter. When both inputs request, the one that was
// not granted last wins; the history only advances when the caller commits
// a grant through 'update'.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       valid,
  output logic       gnt_id
);

  logic last_q;

  // Choose the winner from the current requests and the last grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    valid  = |req;
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // Remember the last committed grant; reset value makes requester 0 win first.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      last_q <= 1'b1;
    end else if (update && valid) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/aes_core_sched.sv
// Schedules encrypt/decrypt jobs from two requesters onto a shared pair of
// AES engines: arbitrate, run one engine with a timeout, then acknowledge.
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   op,
  input  logic [127:0] din0,
  input  logic [127:0] din1,
  output logic [1:0]   gnt,
  output logic [1:0]   ack,
  output logic         err,
  output logic [127:0] dout,
  output logic         busy,
  output logic         en_aes,
  output logic         en_inv_aes,
  output logic [127:0] eng_din,
  input  logic         aes_done,
  input  logic         inv_done,
  input  logic [127:0] aes_dout,
  input  logic [127:0] inv_dout
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic         id_q;
  logic         op_q;
  logic         timed_q;

  logic         arb_valid;
  logic         arb_id;
  logic         arb_update;
  logic         sel_done;
  logic [127:0] sel_dout;

  assign arb_update = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (arb_update),
    .valid  (arb_valid),
    .gnt_id (arb_id)
  );

  // Only the engine that owns the current job may complete it.
  always_comb begin
    sel_done = (op_q == OP_DEC) ? inv_done : aes_done;
    sel_dout = (op_q == OP_DEC) ? inv_dout : aes_dout;
  end

  // Scheduler FSM with registered pulses, enables and data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      op_q       <= OP_ENC;
      timed_q    <= 1'b0;
      gnt        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      dout       <= '0;
      busy       <= 1'b0;
      en_aes     <= 1'b0;
      en_inv_aes <= 1'b0;
      eng_din    <= '0;
    end else begin
      gnt <= '0;
      ack <= '0;
      err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt        <= arb_id ? 2'b10 : 2'b01;
            id_q       <= arb_id;
            op_q       <= op[arb_id];
            eng_din    <= arb_id ? din1 : din0;
            en_aes     <= (op[arb_id] == OP_ENC);
            en_inv_aes <= (op[arb_id] == OP_DEC);
            cnt_q      <= '0;
            busy       <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A completion in the last allowed cycle still beats the timeout.
          if (sel_done) begin
            dout       <= sel_dout;
            timed_q    <= 1'b0;
            en_aes     <= 1'b0;
            en_inv_aes <= 1'b0;
            state_q    <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            dout       <= '0;
            timed_q    <= 1'b1;
            en_aes     <= 1'b0;
            en_inv_aes <= 1'b0;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          ack     <= id_q ? 2'b10 : 2'b01;
          err     <= timed_q;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
